// File: rtl/puertos_salida.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// puertos_salida
// Output-port unit of the processor. The control unit writes a byte to one of
// four output ports (A..D) selected by a 2-bit address. Each port latches the
// byte and hands it to an external device over a four-phase req/ack handshake.
// A write that arrives while its port is still handshaking is dropped and
// recorded in a sticky per-port overflow flag.
//
// Ports
//   clk         processor clock, rising edge
//   reset       asynchronous, active-low reset
//   we_out      one-cycle write strobe
//   dir_out     port address: 0=A, 1=B, 2=C, 3=D
//   datos_in    byte to write
//   clr_ovf     clears every ovf bit (a simultaneous new overflow still sets)
//   ack[3:0]    external acknowledge, bit p = port p (asynchronous to clk)
//   datos_outA..datos_outD  port data registers
//   req[3:0]    data-valid request per port (registered)
//   busy[3:0]   handshake in progress per port (registered)
//   ovf[3:0]    sticky flag: a write to port p was dropped
// -----------------------------------------------------------------------------
module puertos_salida #(
  parameter int WIDTH    = 8,
  parameter int ACK_SYNC = 2   // synchroniser depth on ack: 0 or 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_out,
  input  logic [1:0]       dir_out,
  input  logic [WIDTH-1:0] datos_in,
  input  logic             clr_ovf,
  input  logic [3:0]       ack,
  output logic [WIDTH-1:0] datos_outA,
  output logic [WIDTH-1:0] datos_outB,
  output logic [WIDTH-1:0] datos_outC,
  output logic [WIDTH-1:0] datos_outD,
  output logic [3:0]       req,
  output logic [3:0]       busy,
  output logic [3:0]       ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } portState_t;

  portState_t       state [4];
  logic [WIDTH-1:0] datos [4];
  logic [3:0]       ackS;      // ack after the synchroniser
  logic [3:0]       writeHit;  // write addressed to port p this cycle
  logic [3:0]       dropHit;   // write addressed to a port that is not idle

  // ---------------------------------------------------------------------------
  // ack synchroniser: the device runs on its own timing, so each ack bit passes
  // through ACK_SYNC flops before the FSMs look at it.
  // ---------------------------------------------------------------------------
  generate
    if (ACK_SYNC == 0) begin : g_noSync
      assign ackS = ack;
    end else begin : g_sync
      logic [3:0] syncFf [ACK_SYNC];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < ACK_SYNC; i++) syncFf[i] <= '0;
        end else begin
          syncFf[0] <= ack;
          for (int i = 1; i < ACK_SYNC; i++) syncFf[i] <= syncFf[i-1];
        end
      end

      assign ackS = syncFf[ACK_SYNC-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write decode. A write to a port in REQ or WAIT (including the last WAIT
  // cycle) is dropped and flagged.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    writeHit = '0;
    dropHit  = '0;
    for (int p = 0; p < 4; p++) begin
      writeHit[p] = we_out && (dir_out == 2'(p));
      dropHit[p]  = writeHit[p] && (state[p] != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Port FSMs, data registers and flags. req and busy are registered alongside
  // the state so they change on the same edge as the state they decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are real output ports that must read zero out of
      // reset, so they are reset here like any control flop.
      for (int p = 0; p < 4; p++) begin
        state[p] <= S_IDLE;
        datos[p] <= '0;
      end
      req  <= '0;
      busy <= '0;
      ovf  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the values from before this edge.
      // Set beats clear: a new drop on p survives a simultaneous clr_ovf.
      ovf <= (clr_ovf ? 4'b0000 : ovf) | dropHit;

      for (int p = 0; p < 4; p++) begin
        case (state[p])
          S_IDLE: begin
            // An ack already high while idle is ignored here; the REQ state
            // then completes on the next edge.
            if (writeHit[p]) begin
              datos[p] <= datos_in;
              state[p] <= S_REQ;
              req[p]   <= 1'b1;
              busy[p]  <= 1'b1;
            end
          end
          S_REQ: begin
            if (ackS[p]) begin
              state[p] <= S_WAIT;
              req[p]   <= 1'b0;
            end
          end
          S_WAIT: begin
            if (!ackS[p]) begin
              state[p] <= S_IDLE;
              busy[p]  <= 1'b0;
            end
          end
          default: begin
            state[p] <= S_IDLE;
            req[p]   <= 1'b0;
            busy[p]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign datos_outA = datos[0];
  assign datos_outB = datos[1];
  assign datos_outC = datos[2];
  assign datos_outD = datos[3];

endmodule

// File: tb/tb_puertos_salida.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_puertos_salida
// Bench for puertos_salida (WIDTH=8, ACK_SYNC=2, 60 ns clock). A device model
// answers each port's req; a scoreboard queue holds the writes expected to be
// accepted and is popped each time a req bit rises.
// -----------------------------------------------------------------------------
module tb_puertos_salida;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we_out = 1'b0;
  logic [1:0] dir_out = 2'd0;
  logic [7:0] datos_in = 8'h00;
  logic       clr_ovf = 1'b0;
  logic [3:0] ack = 4'b0000;
  logic [7:0] datos_outA, datos_outB, datos_outC, datos_outD;
  logic [3:0] req, busy, ovf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  logic [3:0] prevReq = 4'b0000;
  int upCnt [4];
  int dnCnt [4];

  puertos_salida #(.WIDTH(8), .ACK_SYNC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .we_out     (we_out),
    .dir_out    (dir_out),
    .datos_in   (datos_in),
    .clr_ovf    (clr_ovf),
    .ack        (ack),
    .datos_outA (datos_outA),
    .datos_outB (datos_outB),
    .datos_outC (datos_outC),
    .datos_outD (datos_outD),
    .req        (req),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #30 clk = ~clk;

  function automatic logic [7:0] dataOf(input int p);
    case (p)
      0: return datos_outA;
      1: return datos_outB;
      2: return datos_outC;
      default: return datos_outD;
    endcase
  endfunction

  // Device model: raises ack about 2 clk after req, drops it after req falls.
  initial begin
    for (int p = 0; p < 4; p++) begin
      upCnt[p] = 0;
      dnCnt[p] = 0;
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (req[p] && !ack[p]) begin
        upCnt[p]++;
        if (upCnt[p] == 2) begin
          ack[p]   = 1'b1;
          upCnt[p] = 0;
        end
      end else if (!req[p] && ack[p]) begin
        dnCnt[p]++;
        if (dnCnt[p] == 2) begin
          ack[p]   = 1'b0;
          dnCnt[p] = 0;
        end
      end else begin
        upCnt[p] = 0;
        dnCnt[p] = 0;
      end
    end
  end

  // Scoreboard monitor: each req rise must match the oldest expected write.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (req[p] && !prevReq[p]) begin
        checks++;
        if (sbQ.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_req port=%0d data=%h, no write was expected", p, dataOf(p));
        end else begin
          monE = sbQ.pop_front();
          if (monE.port != p || dataOf(p) !== monE.data) begin
            failures++;
            $display("FAIL sb_data got port=%0d data=%h expected port=%0d data=%h",
                     p, dataOf(p), monE.port, monE.data);
          end
        end
      end
    end
    prevReq = req;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drv(input int p, input logic [7:0] d, input bit accept);
    @(negedge clk);
    we_out   = 1'b1;
    dir_out  = p[1:0];
    datos_in = d;
    if (accept) sbQ.push_back('{p, d});
  endtask

  task automatic stop_we;
    @(negedge clk);
    we_out = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 4'b0000 || ack !== 4'b0000) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 4'b0000 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b ack=%b expected busy=0000 ack=0000", tag, busy, ack);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({datos_outA, datos_outB, datos_outC, datos_outD, req, busy, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_initial got A=%h B=%h C=%h D=%h req=%b busy=%b ovf=%b expected all zero",
               datos_outA, datos_outB, datos_outC, datos_outD, req, busy, ovf);
    end
    #10 reset = 1'b1;

    // Load some state, then pulse reset mid-cycle and look before any edge.
    drv(1, 8'h3C, 1);
    drv(1, 8'h3D, 0);
    stop_we;
    wait_idle("reset");
    checks++;
    if (datos_outB !== 8'h3C || ovf !== 4'b0010) begin
      failures++;
      $display("FAIL reset_preload got B=%h ovf=%b expected B=3c ovf=0010", datos_outB, ovf);
    end
    @(negedge clk);
    #15 reset = 1'b0;
    #1;
    checks++;
    if ({datos_outA, datos_outB, datos_outC, datos_outD, req, busy, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_async got B=%h req=%b busy=%b ovf=%b expected all zero",
               datos_outB, req, busy, ovf);
    end
    #4 reset = 1'b1;
  endtask

  task automatic test_single;
    int n;
    int edges;
    drv(2, 8'hA5, 1);
    stop_we;
    checks++;
    if (req !== 4'b0100 || datos_outC !== 8'hA5) begin
      failures++;
      $display("FAIL single_req got req=%b C=%h expected req=0100 C=a5", req, datos_outC);
    end

    // req falls 3 edges after ack rises; first edge seeing ack high is edge 1.
    n = 0;
    do begin @(posedge clk); n++; end while (!ack[2] && n < 20);
    edges = 1;
    #1;
    while (req[2] && edges < 10) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges != 3 || n >= 20) begin
      failures++;
      $display("FAIL single_req_fall got edges=%0d expected edges=3", edges);
    end

    n = 0;
    do begin @(posedge clk); n++; end while (ack[2] && n < 20);
    edges = 1;
    #1;
    while (busy[2] && edges < 10) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges != 3 || n >= 20) begin
      failures++;
      $display("FAIL single_busy_fall got edges=%0d expected edges=3", edges);
    end

    wait_idle("single");
    repeat (3) @(negedge clk);
    checks++;
    if (datos_outC !== 8'hA5 || req !== 4'b0000) begin
      failures++;
      $display("FAIL single_hold got C=%h req=%b expected C=a5 req=0000", datos_outC, req);
    end
  endtask

  task automatic test_busy_write;
    drv(0, 8'h11, 1);
    drv(0, 8'h22, 0);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_flag got busy=%b expected busy[0]=1", busy);
    end
    stop_we;
    checks++;
    if (datos_outA !== 8'h11 || ovf !== 4'b0001) begin
      failures++;
      $display("FAIL busy_drop got A=%h ovf=%b expected A=11 ovf=0001", datos_outA, ovf);
    end
    @(negedge clk) clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL busy_clr got ovf=%b expected ovf=0000", ovf);
    end
    wait_idle("busy");
  endtask

  task automatic test_concurrency;
    drv(0, 8'h01, 1);
    drv(1, 8'h02, 1);
    checks++;
    if (req !== 4'b0001) begin
      failures++;
      $display("FAIL conc_stage1 got req=%b expected req=0001", req);
    end
    drv(3, 8'h03, 1);
    checks++;
    if (req !== 4'b0011) begin
      failures++;
      $display("FAIL conc_stage2 got req=%b expected req=0011", req);
    end
    stop_we;
    checks++;
    if (req !== 4'b1011) begin
      failures++;
      $display("FAIL conc_stage3 got req=%b expected req=1011", req);
    end
    wait_idle("conc");
    checks++;
    if (ovf !== 4'b0000 || datos_outA !== 8'h01 || datos_outB !== 8'h02 || datos_outD !== 8'h03) begin
      failures++;
      $display("FAIL conc_final got ovf=%b A=%h B=%h D=%h expected ovf=0000 A=01 B=02 D=03",
               ovf, datos_outA, datos_outB, datos_outD);
    end
  endtask

  task automatic test_set_beats_clear;
    drv(0, 8'h44, 1);
    drv(0, 8'h45, 0);
    drv(3, 8'h46, 1);
    drv(3, 8'h47, 0);
    drv(1, 8'h48, 1);
    checks++;
    if (ovf !== 4'b1001) begin
      failures++;
      $display("FAIL sbc_pre got ovf=%b expected ovf=1001", ovf);
    end
    drv(1, 8'h49, 0);
    clr_ovf = 1'b1;
    stop_we;
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 4'b0010 || datos_outB !== 8'h48) begin
      failures++;
      $display("FAIL sbc_result got ovf=%b B=%h expected ovf=0010 B=48", ovf, datos_outB);
    end
    wait_idle("sbc");
    @(negedge clk) clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid;
    drv(3, 8'h5C, 1);
    stop_we;
    checks++;
    if (req[3] !== 1'b1) begin
      failures++;
      $display("FAIL mid_req got req=%b expected req[3]=1", req);
    end
    #10 reset = 1'b0;
    #1;
    checks++;
    if (req !== 4'b0000 || busy !== 4'b0000 || datos_outD !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got req=%b busy=%b D=%h expected req=0000 busy=0000 D=00",
               req, busy, datos_outD);
    end
    #5 reset = 1'b1;
    wait_idle("mid_pre");
    drv(3, 8'h7E, 1);
    stop_we;
    wait_idle("mid_post");
    checks++;
    if (datos_outD !== 8'h7E || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL mid_after got D=%h ovf=%b expected D=7e ovf=0000", datos_outD, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_write();
    test_concurrency();
    test_set_beats_clear();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d expected pending=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
